// File: rtl/subtrador_pkg.sv
// subtrador_pkg: shared state encoding and slice width for the serial subtractor
package subtrador_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_t;
  localparam int SLICE_W = 4;
endpackage

// File: rtl/subtrador_serial_ctrl_slice.sv
// subtrador_serial_ctrl_slice: 4-bit ripple-borrow subtractor slice, s = a - b - cin
module subtrador_serial_ctrl_slice
  import subtrador_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout
);
  logic [SLICE_W:0] c;
  assign c[0] = cin;
  assign cout = c[SLICE_W];
  for (genvar i = 0; i < SLICE_W; i++) begin : g_bit
    assign s[i] = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & c[i]);
  end
endmodule

// File: rtl/subtrador_serial_ctrl.sv
// subtrador_serial_ctrl: nibble-serial a - b - bin sequencer around one shared 4-bit slice
module subtrador_serial_ctrl
  import subtrador_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero,
  output logic             ovf
);
  localparam int NIB = WIDTH / SLICE_W;
  localparam int IW = NIB > 1 ? $clog2(NIB) : 1;
  if (WIDTH % SLICE_W != 0 || WIDTH < SLICE_W) begin : g_bad_width
    $error("WIDTH must be a positive multiple of 4");
  end
  sub_state_t state, nxt;
  logic [IW-1:0] idx;
  logic [WIDTH-1:0] op_a, op_b, res;
  logic brw, cout;
  logic [SLICE_W-1:0] s;
  subtrador_serial_ctrl_slice u_slice (
    .a(op_a[SLICE_W*idx +: SLICE_W]),
    .b(op_b[SLICE_W*idx +: SLICE_W]),
    .cin(brw),
    .s(s),
    .cout(cout)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = clear ? IDLE :
          state == IDLE ? (start ? RUN : IDLE) :
          state == RUN ? (idx == IW'(NIB - 1) ? DONE : RUN) : IDLE;
  always_comb begin
    ready = state == IDLE;
    busy = state == RUN;
  end
  // flags are decoded from the completed result so the outputs never show a partial value
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx <= '0;
      op_a <= '0;
      op_b <= '0;
      brw <= 1'b0;
      res <= '0;
      done <= 1'b0;
      diff <= '0;
      borrow_out <= 1'b0;
      zero <= 1'b0;
      ovf <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clear) idx <= '0;
      else if (state == IDLE && start) begin
        op_a <= a;
        op_b <= b;
        brw <= bin;
        idx <= '0;
        res <= '0;
      end else if (state == RUN) begin
        res[SLICE_W*idx +: SLICE_W] <= s;
        brw <= cout;
        idx <= idx + IW'(1);
      end else if (state == DONE) begin
        done <= 1'b1;
        diff <= res;
        borrow_out <= brw;
        zero <= res == '0;
        ovf <= (op_a[WIDTH-1] ^ op_b[WIDTH-1]) && (res[WIDTH-1] ^ op_a[WIDTH-1]);
      end
    end
endmodule

// File: tb/tb_subtrador_serial_ctrl.sv
// tb_subtrador_serial_ctrl: table, directed and random scoreboard checks of the serial subtractor
module tb_subtrador_serial_ctrl;
  logic clk, rst_n, start, clear, bin, go;
  logic [15:0] a, b, diff;
  logic ready, busy, done, borrow_out, zero, ovf;
  int npass, ntot, nstart, ndone, n0;
  logic [34:0] sq[$];
  typedef struct {
    logic [15:0] a, b;
    logic bin;
    logic [15:0] d;
    logic bo, z, o;
  } vec_t;
  vec_t tv[7];
  subtrador_serial_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .a(a), .b(b), .bin(bin),
    .ready(ready), .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out),
    .zero(zero), .ovf(ovf)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h want %0h", n, got, exp);
  endtask
  function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y, input logic c, input int w);
    logic [63:0] m, t;
    logic [31:0] d;
    m = (64'd1 << w) - 64'd1;
    t = ({32'd0, x} & m) - ({32'd0, y} & m) - 64'(c);
    d = 32'(t & m);
    return {t[w], d == 0, (x[w-1] != y[w-1]) && (d[w-1] != x[w-1]), d};
  endfunction
  always @(negedge clk)
    if (done) begin
      ndone++;
      if (sq.size() == 0) chk("spurious_done", 64'(sq.size()), 1);
      else chk("result16", {borrow_out, zero, ovf, 16'd0, diff}, sq.pop_front());
    end
  task automatic op16(input logic [15:0] xa, input logic [15:0] xb, input logic xc, input logic [34:0] e);
    int n;
    @(negedge clk);
    a = xa; b = xb; bin = xc; start = 1;
    sq.push_back(e);
    nstart++;
    for (n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      start = 0;
      if (done) break;
    end
    chk("latency16", 64'(n), 6);
  endtask
  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask
  for (genvar g = 0; g < 2; g++) begin : gw
    localparam int W = g ? 32 : 4;
    logic st, xbin, rdy, bsy, dn, bo, zr, ov, fin, ok;
    logic [W-1:0] xa, xb, df;
    logic [34:0] q[$];
    int ns, nd;
    subtrador_serial_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(st), .clear(1'b0), .a(xa), .b(xb), .bin(xbin),
      .ready(rdy), .busy(bsy), .done(dn), .diff(df), .borrow_out(bo), .zero(zr), .ovf(ov)
    );
    always @(negedge clk)
      if (dn) begin
        nd++;
        if (q.size() == 0) chk($sformatf("spurious_done_w%0d", W), 64'(q.size()), 1);
        else chk($sformatf("result_w%0d", W), {bo, zr, ov, 32'(df)}, q.pop_front());
      end
    initial begin
      fin = 0; st = 0; xa = '0; xb = '0; xbin = 0; ns = 0; nd = 0;
      wait (go);
      for (int i = 0; i < 333; i++) begin
        @(negedge clk);
        xa = W'($urandom);
        xb = (i % 8 == 0) ? xa : W'($urandom);
        xbin = 1'($urandom);
        st = 1;
        q.push_back(model(32'(xa), 32'(xb), xbin, W));
        ns++;
        @(negedge clk);
        st = 0;
        ok = 0;
        for (int k = 0; k < 40 && !ok; k++) begin
          @(negedge clk);
          ok = dn;
        end
        if (!ok) chk($sformatf("timeout_w%0d", W), 0, 1);
      end
      idle(12);
      chk($sformatf("done_count_w%0d", W), 64'(nd), 64'(ns));
      fin = 1;
    end
  end
  initial begin
    npass = 0; ntot = 0; nstart = 0; ndone = 0; go = 0;
    rst_n = 0; start = 0; clear = 0; a = '0; b = '0; bin = 0;
    tv[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
    tv[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    tv[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1};
    tv[3] = '{16'hABCD, 16'hABCD, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
    tv[4] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    tv[5] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1};
    tv[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    idle(3);
    chk("reset_ctl", {ready, busy, done}, 3'b100);
    chk("reset_out", {borrow_out, zero, ovf, diff}, 0);
    rst_n = 1;
    idle(2);
    chk("idle_ctl", {ready, busy, done}, 3'b100);
    for (int i = 0; i < 7; i++)
      op16(tv[i].a, tv[i].b, tv[i].bin, {tv[i].bo, tv[i].z, tv[i].o, 16'd0, tv[i].d});
    idle(2);
    n0 = ndone;
    @(negedge clk);
    a = 16'h4321; b = 16'h1111; bin = 0; start = 1;
    sq.push_back({3'b000, 16'd0, 16'h3210});
    nstart++;
    @(posedge clk); #1 start = 0;
    @(posedge clk); #1;
    chk("run_ctl", {ready, busy}, 2'b01);
    a = 16'hFFFF; b = 16'h0001; bin = 1; start = 1;
    begin
      int n;
      for (n = 3; n <= 20; n++) begin
        @(posedge clk); #1;
        start = 0;
        if (done) break;
      end
      chk("latency_ignore", 64'(n), 6);
    end
    chk("ready_after_done", ready, 1);
    @(posedge clk); #1;
    chk("ready_start7", {ready, busy, done}, 3'b100);
    idle(12);
    chk("ignored_start_dones", 64'(ndone - n0), 1);
    n0 = ndone;
    @(negedge clk);
    a = 16'h0000; b = 16'h0001; bin = 0; start = 1;
    @(posedge clk); #1 start = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("async_rst_out", {borrow_out, zero, ovf, diff}, 0);
    chk("async_rst_ctl", {ready, busy, done}, 3'b100);
    @(negedge clk) rst_n = 1;
    idle(12);
    chk("rst_no_done", 64'(ndone - n0), 0);
    op16(16'h1234, 16'h0234, 1'b0, {3'b000, 16'd0, 16'h1000});
    idle(2);
    n0 = ndone;
    @(negedge clk);
    a = 16'h0000; b = 16'h0001; bin = 0; start = 1;
    @(posedge clk); #1 start = 0;
    @(posedge clk); #1 clear = 1;
    @(posedge clk); #1 clear = 0;
    chk("clear_ctl", {ready, busy, done}, 3'b100);
    idle(12);
    chk("clear_no_done", 64'(ndone - n0), 0);
    chk("clear_keep", {borrow_out, zero, ovf, diff}, {3'b000, 16'h1000});
    @(negedge clk);
    start = 1; clear = 1;
    @(posedge clk); #1;
    start = 0; clear = 0;
    chk("clear_over_start", {ready, busy}, 2'b10);
    idle(12);
    chk("clear_start_no_done", 64'(ndone - n0), 0);
    go = 1;
    for (int i = 0; i < 334; i++) begin
      logic [15:0] ra, rb;
      logic rc;
      ra = 16'($urandom);
      rb = (i % 8 == 0) ? ra : 16'($urandom);
      rc = 1'($urandom);
      op16(ra, rb, rc, model(32'(ra), 32'(rb), rc, 16));
    end
    for (int k = 0; k < 60000 && !(gw[0].fin && gw[1].fin); k++) @(negedge clk);
    chk("random_finished", {gw[1].fin, gw[0].fin}, 2'b11);
    idle(4);
    chk("done_count16", 64'(ndone), 64'(nstart));
    chk("queue_empty16", 64'(sq.size()), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
